// File: rtl/fetch_decode_unit.sv
// PC, instruction register and opcode pre-decode beside the FETCH/EXEC1/EXEC2 sequencer.
// IR/PC update one edge after FETCH; E2/LAST_EXEC combinational; no backpressure (strobe-driven).
module fetch_decode_unit #(
    parameter int               ADDR_W   = 16,
    parameter int               INSTR_W  = 16,
    parameter int               CNT_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [15:0]      E2_MASK  = 16'h00F0,
    parameter logic [3:0]       HALT_OPC = 4'hF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_fetch,
    input  logic               i_exec1,
    input  logic               i_exec2,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    input  logic               i_jmp,
    input  logic [ADDR_W-1:0]  i_jmp_addr,
    output logic [ADDR_W-1:0]  o_imem_addr,
    output logic [INSTR_W-1:0] o_ir,
    output logic [3:0]         o_opcode,
    output logic               o_e2,
    output logic               o_last_exec,
    output logic               o_halted,
    output logic               o_err,
    output logic [CNT_W-1:0]   o_retired
);

    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic               r_halted;
    logic               r_err;
    logic [CNT_W-1:0]   r_retired;

    logic       w_valid;
    logic [3:0] w_opcode;
    logic       w_e2;
    logic       w_last;
    logic       w_is_halt;

    // Exactly one sequencer strobe must be high; anything else is a protocol error.
    assign w_valid = ( i_fetch & ~i_exec1 & ~i_exec2) |
                     (~i_fetch &  i_exec1 & ~i_exec2) |
                     (~i_fetch & ~i_exec1 &  i_exec2);

    assign w_opcode  = r_ir[INSTR_W-1 -: 4];
    assign w_e2      = i_exec1 & E2_MASK[w_opcode] & ~r_halted;
    assign w_last    = (i_exec1 & ~w_e2) | i_exec2;
    assign w_is_halt = (w_opcode == HALT_OPC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_halted  <= 1'b0;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else if (!w_valid) begin
            r_err <= 1'b1;
        end else if (!r_halted) begin
            if (i_fetch) begin
                r_ir <= i_imem_rdata;
                r_pc <= r_pc + ADDR_W'(1);
            end
            if (w_last) begin
                r_retired <= r_retired + CNT_W'(1);
                // A halting instruction never jumps.
                if (w_is_halt) begin
                    r_halted <= 1'b1;
                end else if (i_jmp) begin
                    r_pc <= i_jmp_addr;
                end
            end
        end
    end

    assign o_imem_addr = r_pc;
    assign o_ir        = r_ir;
    assign o_opcode    = w_opcode;
    assign o_e2        = w_e2;
    assign o_last_exec = w_last;
    assign o_halted    = r_halted;
    assign o_err       = r_err;
    assign o_retired   = r_retired;

endmodule
